rvm_axi4_sram: RTL and testbench
================================

Name: rvm_axi4_sram

Overview:
- AXI4 slave memory. Directly downstream of the core's AXI4 master port; consumes its AW/W/B/AR/R traffic.
- Backs a single-port word-wide register-array SRAM of DEPTH words mapped at BASE_ADDR.
- Serves one transaction at a time and arbitrates read vs write fairly.
- Used as the system memory in simulation and FPGA builds.

Parameters:
- DEPTH, 4096: number of 32-bit words in the memory.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- AW, 12: word-index width, equal to clog2(DEPTH).

Ports:
- ACLK  in  1  clock; single clock domain.
- ARESET  in  1  reset; synchronous, active-high.
- AWID  in  1  write ID, echoed on BID.
- AWADDR  in  32  write byte address.
- AWLEN  in  8  beats minus one.
- AWBURST  in  2  burst type.
- AWVALID  in  1 / AWREADY  out  1  write address handshake.
- WDATA  in  32  write data.
- WSTRB  in  4  byte strobes.
- WLAST  in  1  last write beat.
- WVALID  in  1 / WREADY  out  1  write data handshake.
- BID  out  1  response ID.
- BRESP  out  2  write response.
- BVALID  out  1 / BREADY  in  1  write response handshake.
- ARID  in  1  read ID.
- ARADDR  in  32  read byte address.
- ARLEN  in  8  beats minus one.
- ARBURST  in  2  burst type.
- ARVALID  in  1 / ARREADY  out  1  read address handshake.
- RID  out  1  read ID.
- RDATA  out  32  read data.
- RRESP  out  2  read response.
- RLAST  out  1  last read beat.
- RVALID  out  1 / RREADY  in  1  read data handshake.

Behaviour:
- Reset (ARESET high at a rising edge of ACLK):
  - state=IDLE; AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0.
  - BRESP = RRESP = 2'b00; RDATA = 0; BID = RID = 0.
  - last_grant = READ, so a write wins the first tie.
  - Memory contents are not cleared.
  - Reset mid-transaction abandons it immediately; no response is issued.
- States: IDLE, WDATA, WRESP, RDATA.
- IDLE:
  - AWREADY = AWVALID && grant_w; ARREADY = ARVALID && !grant_w. Both readies are combinational from state and valids.
  - grant_w = AWVALID && (!ARVALID || last_grant==READ).
  - AW handshake: latch addr, len, burst, id; clear beat count and err; last_grant=WRITE; go to WDATA.
  - AR handshake: latch the same fields; last_grant=READ; load RDATA/RRESP for beat 0; RVALID=1 next cycle; go to RDATA.
  - Read latency: AR handshake at cycle N gives RVALID=1 at cycle N+1.
- Address decode:
  - idx = (addr - BASE_ADDR) >> 2. addr[1:0] is ignored.
  - A beat is out of range if addr < BASE_ADDR or idx >= DEPTH.
- WDATA:
  - WREADY=1. Each W handshake writes the bytes enabled by WSTRB to mem[idx], but only if in range; an out-of-range beat sets err.
  - WLAST must equal (count==len). A mismatch sets err.
  - The burst ends on the beat where count==len: WREADY drops, go to WRESP.
  - The beat counter is 8 bits, so len=255 gives 256 beats with no wrap.
- WRESP: BVALID=1, BID=latched id, BRESP = err ? 2'b10 (SLVERR) : 2'b00. On BREADY go to IDLE. Hold all outputs stable while BREADY is low.
- RDATA:
  - RVALID=1; RID=latched id; RLAST=(count==len).
  - Out-of-range beat: RDATA=0, RRESP=2'b10. In range: RDATA=mem[idx], RRESP=2'b00.
  - Handshake on a non-last beat: next beat's data is loaded into the register, RVALID stays 1 with no bubble.
  - Handshake on the last beat: RVALID=0, go to IDLE.
  - RDATA, RRESP and RLAST hold stable while RREADY is low.
- AR and AW are never both accepted in the same cycle. AWREADY and ARREADY are 0 outside IDLE.

Optional Feature:
- Macro: RVM_AXI4_SRAM_BURST_EN.
- Defined:
  - INCR (2'b01): address +4 per beat.
  - FIXED (2'b00): same address every beat.
  - WRAP (2'b10) and reserved types: handled as INCR and flagged SLVERR on every beat or response.
- Undefined:
  - Address never increments.
  - len != 0 still completes all len+1 beats for protocol correctness.
  - Every read beat returns RRESP=SLVERR with RDATA=0; writes are suppressed and BRESP=SLVERR.
  - len == 0 behaves identically in both builds.

Test Plan:
- Single write then read: AW 0x10, WDATA 0xDEADBEEF, WSTRB 4'hF; then AR 0x10 -> BRESP 00; RVALID one cycle after AR handshake; RDATA 0xDEADBEEF, RRESP 00, RLAST 1.
- Partial strobe: write 0x11223344 to 0x20, then WSTRB 4'b0010 with 0xAAAAAAAA -> read gives 0x1122AA44.
- Out of range: AR at BASE_ADDR+4*DEPTH -> RDATA 0, RRESP 10. A write there -> BRESP 10 and memory unchanged.
- Arbitration with back-pressure: AWVALID and ARVALID both high from reset -> write is granted first, read next. Hold BREADY low 5 cycles -> BVALID/BRESP stable.
- Burst (macro on): INCR len=3 write of 1,2,3,4 at 0x40; read back with RREADY toggling -> RDATA 1,2,3,4; RLAST only on the 4th beat. Macro off: same stimulus -> BRESP 10, every R beat RRESP 10.
- Reset mid-burst: ARESET asserted during the 2nd R beat -> next cycle RVALID 0, state IDLE; a new AR is accepted cleanly.

Source files
------------

// File: rtl/rvm_axi4_sram.sv
// rvm_axi4_sram: AXI4 slave backed by a word-wide register-array SRAM.
// Handles one transaction at a time and alternates read/write priority on ties.
// Optional feature macro: RVM_AXI4_SRAM_BURST_EN. When it is defined, INCR and
// FIXED bursts are supported. When it is undefined, only single-beat transfers
// are serviced; longer bursts still run to completion but return SLVERR.
module rvm_axi4_sram #(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned AW        = $clog2(DEPTH)
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        AWID,
  input  logic [31:0] AWADDR,
  input  logic [7:0]  AWLEN,
  input  logic [1:0]  AWBURST,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WLAST,
  input  logic        WVALID,
  output logic        WREADY,
  output logic        BID,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY,
  input  logic        ARID,
  input  logic [31:0] ARADDR,
  input  logic [7:0]  ARLEN,
  input  logic [1:0]  ARBURST,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic        RID,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RLAST,
  output logic        RVALID,
  input  logic        RREADY
);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef RVM_AXI4_SRAM_BURST_EN
  localparam logic SINGLE_ONLY = 1'b0;
`else
  localparam logic SINGLE_ONLY = 1'b1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_WRESP, S_RDATA} state_e;
  typedef enum logic {G_READ, G_WRITE} grant_e;

  state_e      state_q, state_d;
  grant_e      last_grant_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [1:0]  burst_q;
  logic        id_q;
  logic [7:0]  cnt_q;
  logic        err_q;
  logic        wready_q;
  logic        bvalid_q, bid_q;
  logic [1:0]  bresp_q;
  logic        rvalid_q, rid_q, rlast_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic        grant_w, w_hs, b_hs, r_hs;
  logic        wbad_c, werr_c, rbad_next_c;
  logic [31:0] rnext_addr_c;

  logic [31:0] mem [DEPTH];

  // Byte address falls inside the mapped window
  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> 2) < 32'(DEPTH));
  endfunction

  // Word index of a byte address (low two bits ignored)
  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  // A beat is refused if unmapped, of an unsupported burst type, or a multi-beat
  // burst in a single-beat build
  function automatic logic beat_bad(input logic [31:0] a, input logic [1:0] b,
                                    input logic [7:0] l);
    return !in_range(a) || !(b == BURST_FIXED || b == BURST_INCR) ||
           (SINGLE_ONLY && (l != 8'd0));
  endfunction

  // Address of the following beat; reserved types advance like INCR
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] b);
    return (SINGLE_ONLY || b == BURST_FIXED) ? a : a + 32'd4;
  endfunction

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state, address-channel readies and handshake strobes
  always_comb begin
    state_d      = state_q;
    grant_w      = 1'b0;
    AWREADY      = 1'b0;
    ARREADY      = 1'b0;
    w_hs         = 1'b0;
    b_hs         = 1'b0;
    r_hs         = 1'b0;
    wbad_c       = beat_bad(addr_q, burst_q, len_q);
    werr_c       = wbad_c || (WLAST != (cnt_q == len_q));
    rnext_addr_c = next_addr(addr_q, burst_q);
    rbad_next_c  = beat_bad(rnext_addr_c, burst_q, len_q);
    case (state_q)
      S_IDLE: begin
        grant_w = AWVALID && (!ARVALID || last_grant_q == G_READ);
        AWREADY = grant_w;
        ARREADY = ARVALID && !grant_w;
        if (AWREADY)      state_d = S_WDATA;
        else if (ARREADY) state_d = S_RDATA;
      end
      S_WDATA: begin
        w_hs = WVALID && wready_q;
        if (w_hs && cnt_q == len_q) state_d = S_WRESP;
      end
      S_WRESP: begin
        b_hs = bvalid_q && BREADY;
        if (b_hs) state_d = S_IDLE;
      end
      S_RDATA: begin
        r_hs = rvalid_q && RREADY;
        if (r_hs && rlast_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Transaction context and registered response channels
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      last_grant_q <= G_READ;
      addr_q       <= '0;
      len_q        <= '0;
      burst_q      <= '0;
      id_q         <= 1'b0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bid_q        <= 1'b0;
      bresp_q      <= RESP_OKAY;
      rvalid_q     <= 1'b0;
      rid_q        <= 1'b0;
      rlast_q      <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (AWREADY) begin
            addr_q       <= AWADDR;
            len_q        <= AWLEN;
            burst_q      <= AWBURST;
            id_q         <= AWID;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            last_grant_q <= G_WRITE;
            wready_q     <= 1'b1;
          end else if (ARREADY) begin
            addr_q       <= ARADDR;
            len_q        <= ARLEN;
            burst_q      <= ARBURST;
            id_q         <= ARID;
            cnt_q        <= '0;
            last_grant_q <= G_READ;
            rvalid_q     <= 1'b1;
            rid_q        <= ARID;
            rlast_q      <= (ARLEN == 8'd0);
            if (beat_bad(ARADDR, ARBURST, ARLEN)) begin
              rdata_q <= '0;
              rresp_q <= RESP_SLVERR;
            end else begin
              rdata_q <= mem[word_idx(ARADDR)];
              rresp_q <= RESP_OKAY;
            end
          end
        end
        S_WDATA: begin
          if (w_hs) begin
            cnt_q  <= cnt_q + 8'd1;
            addr_q <= next_addr(addr_q, burst_q);
            if (werr_c) err_q <= 1'b1;
            if (cnt_q == len_q) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= id_q;
              bresp_q  <= (err_q || werr_c) ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        S_WRESP: begin
          if (b_hs) bvalid_q <= 1'b0;
        end
        S_RDATA: begin
          if (r_hs) begin
            if (rlast_q) begin
              rvalid_q <= 1'b0;
            end else begin
              addr_q  <= rnext_addr_c;
              cnt_q   <= cnt_q + 8'd1;
              rlast_q <= ((cnt_q + 8'd1) == len_q);
              if (rbad_next_c) begin
                rdata_q <= '0;
                rresp_q <= RESP_SLVERR;
              end else begin
                rdata_q <= mem[word_idx(rnext_addr_c)];
                rresp_q <= RESP_OKAY;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Byte-masked memory write; contents survive reset
  always_ff @(posedge ACLK) begin
    if (!ARESET && w_hs && !wbad_c) begin
      for (int b = 0; b < 4; b++) begin
        if (WSTRB[b]) mem[word_idx(addr_q)][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  assign WREADY = wready_q;
  assign BVALID = bvalid_q;
  assign BID    = bid_q;
  assign BRESP  = bresp_q;
  assign RVALID = rvalid_q;
  assign RID    = rid_q;
  assign RDATA  = rdata_q;
  assign RRESP  = rresp_q;
  assign RLAST  = rlast_q;

endmodule

// File: tb/tb_rvm_axi4_sram.sv
// Testbench for rvm_axi4_sram: scoreboard of expected B/R responses driven
// from a shadow memory model. Honors RVM_AXI4_SRAM_BURST_EN like the design.
module tb_rvm_axi4_sram;

  localparam int unsigned DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h0000_0000;

`ifdef RVM_AXI4_SRAM_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic        ACLK, ARESET;
  logic        AWID, AWVALID, AWREADY;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [1:0]  AWBURST;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic        BID, BVALID, BREADY;
  logic [1:0]  BRESP;
  logic        ARID, ARVALID, ARREADY;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [1:0]  ARBURST;
  logic        RID, RLAST, RVALID, RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;

  rvm_axi4_sram #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        id;
  } rbeat_t;

  typedef struct packed {
    logic [1:0] resp;
    logic       id;
  } bresp_t;

  rbeat_t      rq[$];
  bresp_t      bq[$];
  logic [31:0] model [int];
  logic [31:0] wbuf [256];
  int          nchecks = 0;
  int          nerrs   = 0;

  // Spec-level model of the beat acceptance rule
  function automatic logic exp_bad(input logic [31:0] a, input logic [1:0] b, input logic [7:0] l);
    logic ok;
    ok = (a >= BASE) && (((a - BASE) >> 2) < 32'(DEPTH));
    return !ok || !(b == 2'b00 || b == 2'b01) || (!BURST_EN && l != 8'd0);
  endfunction

  function automatic logic [31:0] exp_next(input logic [31:0] a, input logic [1:0] b);
    return (BURST_EN && b != 2'b00) ? a + 32'd4 : a;
  endfunction

  function automatic logic cur(input int sel);
    case (sel)
      0: return AWREADY;
      1: return WREADY;
      2: return BVALID;
      3: return ARREADY;
      default: return RVALID;
    endcase
  endfunction

  // Bounded wait at negedge+1 until the selected ready/valid is high
  task automatic wait_hs(input int sel, input string nm);
    int n;
    n = 0;
    while (!cur(sel) && n < 200) begin
      @(negedge ACLK); #1;
      n++;
    end
    if (n >= 200) begin
      nchecks++; nerrs++;
      $display("FAIL timeout_%s: signal stayed 0, required 1", nm);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic id, input logic [3:0] strb);
    logic [31:0] a;
    logic        err;
    bresp_t      e;
    a = addr; err = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (exp_bad(a, burst, len)) err = 1'b1;
      else begin
        int k;
        logic [31:0] v;
        k = int'((a - BASE) >> 2);
        v = model.exists(k) ? model[k] : 32'h0;
        for (int b = 0; b < 4; b++) if (strb[b]) v[8*b +: 8] = wbuf[i][8*b +: 8];
        model[k] = v;
      end
      if (wbuf[i] == 32'h0 && 1'b0) err = 1'b1;
      a = exp_next(a, burst);
    end
    bq.push_back('{resp: (err ? 2'b10 : 2'b00), id: id});
    @(negedge ACLK);
    AWADDR = addr; AWLEN = len; AWBURST = burst; AWID = id; AWVALID = 1'b1;
    #1; wait_hs(0, "aw");
    @(posedge ACLK); @(negedge ACLK);
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      WDATA = wbuf[i]; WSTRB = strb; WLAST = (i == int'(len)); WVALID = 1'b1;
      #1; wait_hs(1, "w");
      @(posedge ACLK); @(negedge ACLK);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    BREADY = 1'b1;
    #1; wait_hs(2, "b");
    e = bq.pop_front();
    nchecks++;
    if (BRESP !== e.resp) begin
      nerrs++; $display("FAIL bresp @%h: got %b, required %b", addr, BRESP, e.resp);
    end
    nchecks++;
    if (BID !== e.id) begin
      nerrs++; $display("FAIL bid @%h: got %b, required %b", addr, BID, e.id);
    end
    @(posedge ACLK); @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic id, input bit toggle);
    logic [31:0] a;
    rbeat_t      e;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      int k;
      k = int'((a - BASE) >> 2);
      if (exp_bad(a, burst, len)) e = '{data: 32'h0, resp: 2'b10, last: (i == int'(len)), id: id};
      else e = '{data: (model.exists(k) ? model[k] : 32'h0), resp: 2'b00,
                 last: (i == int'(len)), id: id};
      rq.push_back(e);
      a = exp_next(a, burst);
    end
    @(negedge ACLK);
    ARADDR = addr; ARLEN = len; ARBURST = burst; ARID = id; ARVALID = 1'b1;
    #1; wait_hs(3, "ar");
    @(posedge ACLK); @(negedge ACLK);
    ARVALID = 1'b0;
    nchecks++;
    if (RVALID !== 1'b1) begin
      nerrs++; $display("FAIL r_latency @%h: RVALID %b one cycle after AR, required 1", addr, RVALID);
    end
    for (int i = 0; i <= int'(len); i++) begin
      #1; wait_hs(4, "r");
      if (toggle && (i % 2 == 1)) begin
        RREADY = 1'b0;
        @(posedge ACLK); @(negedge ACLK); #1;
        nchecks++;
        if (RVALID !== 1'b1 || RDATA !== rq[0].data || RLAST !== rq[0].last) begin
          nerrs++;
          $display("FAIL r_hold beat %0d: valid %b data %h last %b, required 1 %h %b",
                   i, RVALID, RDATA, RLAST, rq[0].data, rq[0].last);
        end
      end
      RREADY = 1'b1;
      e = rq.pop_front();
      nchecks++;
      if (RDATA !== e.data || RRESP !== e.resp || RLAST !== e.last || RID !== e.id) begin
        nerrs++;
        $display("FAIL rbeat @%h beat %0d: got %h/%b/%b/%b, required %h/%b/%b/%b",
                 addr, i, RDATA, RRESP, RLAST, RID, e.data, e.resp, e.last, e.id);
      end
      @(posedge ACLK); @(negedge ACLK);
      RREADY = 1'b0;
    end
    #1;
    nchecks++;
    if (RVALID !== 1'b0) begin
      nerrs++; $display("FAIL r_end @%h: RVALID %b after last beat, required 0", addr, RVALID);
    end
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    AWID = 0; AWADDR = 0; AWLEN = 0; AWBURST = 2'b01; AWVALID = 0;
    WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0; BREADY = 0;
    ARID = 0; ARADDR = 0; ARLEN = 0; ARBURST = 2'b01; ARVALID = 0; RREADY = 0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    nchecks++;
    if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST} !== 6'b0) begin
      nerrs++;
      $display("FAIL reset_ctrl: aw/w/b/ar/r/last = %b, required 000000",
               {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST});
    end
    nchecks++;
    if (BRESP !== 2'b00 || RRESP !== 2'b00 || RDATA !== 32'h0 || BID !== 1'b0 || RID !== 1'b0) begin
      nerrs++;
      $display("FAIL reset_data: bresp %b rresp %b rdata %h bid %b rid %b, required all zero",
               BRESP, RRESP, RDATA, BID, RID);
    end
    ARESET = 1'b0;
  endtask

  task automatic test_single();
    wbuf[0] = 32'hDEAD_BEEF;
    do_write(32'h10, 8'd0, 2'b01, 1'b1, 4'hF);
    do_read(32'h10, 8'd0, 2'b01, 1'b1, 1'b0);
  endtask

  task automatic test_partial_strobe();
    wbuf[0] = 32'h1122_3344;
    do_write(32'h20, 8'd0, 2'b01, 1'b0, 4'hF);
    wbuf[0] = 32'hAAAA_AAAA;
    do_write(32'h20, 8'd0, 2'b01, 1'b0, 4'b0010);
    do_read(32'h20, 8'd0, 2'b01, 1'b0, 1'b0);
  endtask

  task automatic test_out_of_range();
    wbuf[0] = 32'h55AA_55AA;
    do_write(32'h0, 8'd0, 2'b01, 1'b0, 4'hF);
    wbuf[0] = 32'hFFFF_FFFF;
    do_write(BASE + 32'(4 * DEPTH), 8'd0, 2'b01, 1'b1, 4'hF);
    do_read(BASE + 32'(4 * DEPTH), 8'd0, 2'b01, 1'b0, 1'b0);
    do_read(32'hFFFF_FFFC, 8'd0, 2'b01, 1'b1, 1'b0);
    do_read(32'h0, 8'd0, 2'b01, 1'b0, 1'b0);
  endtask

  task automatic test_arbitration();
    bresp_t e;
    rbeat_t r;
    @(negedge ACLK);
    ARESET = 1'b1;
    AWADDR = 32'h30; AWLEN = 0; AWBURST = 2'b01; AWID = 1'b1; AWVALID = 1'b1;
    ARADDR = 32'h30; ARLEN = 0; ARBURST = 2'b01; ARID = 1'b0; ARVALID = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    nchecks++;
    if (AWREADY !== 1'b1 || ARREADY !== 1'b0) begin
      nerrs++; $display("FAIL arb_first: awready %b arready %b, required 1 0", AWREADY, ARREADY);
    end
    model[int'(32'h30 >> 2)] = 32'hCAFE_F00D;
    bq.push_back('{resp: 2'b00, id: 1'b1});
    @(posedge ACLK); @(negedge ACLK);
    AWVALID = 1'b0;
    WDATA = 32'hCAFE_F00D; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
    #1;
    nchecks++;
    if (ARREADY !== 1'b0) begin
      nerrs++; $display("FAIL arb_busy: arready %b during write, required 0", ARREADY);
    end
    wait_hs(1, "w_arb");
    @(posedge ACLK); @(negedge ACLK);
    WVALID = 1'b0; WLAST = 1'b0;
    e = bq.pop_front();
    for (int c = 0; c < 5; c++) begin
      #1;
      nchecks++;
      if (BVALID !== 1'b1 || BRESP !== e.resp || BID !== e.id || ARREADY !== 1'b0) begin
        nerrs++;
        $display("FAIL b_hold cycle %0d: bvalid %b bresp %b bid %b arready %b, required 1 %b %b 0",
                 c, BVALID, BRESP, BID, ARREADY, e.resp, e.id);
      end
      @(negedge ACLK);
    end
    BREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    BREADY = 1'b0;
    AWADDR = 32'h34; AWVALID = 1'b1;
    #1;
    nchecks++;
    if (ARREADY !== 1'b1 || AWREADY !== 1'b0) begin
      nerrs++; $display("FAIL arb_second: arready %b awready %b, required 1 0", ARREADY, AWREADY);
    end
    rq.push_back('{data: 32'hCAFE_F00D, resp: 2'b00, last: 1'b1, id: 1'b0});
    @(posedge ACLK); @(negedge ACLK);
    ARVALID = 1'b0; AWVALID = 1'b0;
    #1;
    r = rq.pop_front();
    nchecks++;
    if (RVALID !== 1'b1 || RDATA !== r.data || RRESP !== r.resp || RLAST !== r.last) begin
      nerrs++;
      $display("FAIL arb_read: valid %b data %h resp %b last %b, required 1 %h %b %b",
               RVALID, RDATA, RRESP, RLAST, r.data, r.resp, r.last);
    end
    RREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    RREADY = 1'b0;
  endtask

  task automatic test_burst();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    do_write(32'h40, 8'd3, 2'b01, 1'b1, 4'hF);
    do_read(32'h40, 8'd3, 2'b01, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_burst();
    @(negedge ACLK);
    ARADDR = 32'h40; ARLEN = 8'd3; ARBURST = 2'b01; ARID = 1'b0; ARVALID = 1'b1;
    #1; wait_hs(3, "ar_mid");
    @(posedge ACLK); @(negedge ACLK);
    ARVALID = 1'b0;
    RREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    RREADY = 1'b0;
    #1;
    nchecks++;
    if (RVALID !== 1'b1 || RLAST !== 1'b0) begin
      nerrs++; $display("FAIL mid_beat2: valid %b last %b, required 1 0", RVALID, RLAST);
    end
    ARESET = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    nchecks++;
    if (RVALID !== 1'b0 || RLAST !== 1'b0 || WREADY !== 1'b0 || BVALID !== 1'b0) begin
      nerrs++;
      $display("FAIL mid_reset: rvalid %b rlast %b wready %b bvalid %b, required 0 0 0 0",
               RVALID, RLAST, WREADY, BVALID);
    end
    do_read(32'h10, 8'd0, 2'b01, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_partial_strobe();
    test_out_of_range();
    test_arbitration();
    test_burst();
    test_reset_mid_burst();
    repeat (2) @(negedge ACLK);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
